// File: rtl/rf_sched_pkg.sv
// Shared encodings for the register-file operand scheduler.
package rf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } rd_state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rf_wr_arb.sv
// Two-source round-robin write arbiter for the register-file write port.
module rf_wr_arb
    import rf_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wa_req,
    input  logic [DEPTH-1:0] wa_addr,
    input  logic [WIDTH-1:0] wa_data,
    output logic             wa_ack,
    input  logic             wb_req,
    input  logic [DEPTH-1:0] wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_ack,
    output logic             wr_en,
    output logic [DEPTH-1:0] w_addr,
    output logic [WIDTH-1:0] w_data
);

    src_e last_q;
    src_e last_d;

    always_comb begin
        wa_ack = 1'b0;
        wb_ack = 1'b0;
        last_d = last_q;
        // Grants are suppressed while clr is high, even though it is asynchronous.
        if (!clr) begin
            if (wa_req && wb_req) begin
                if (last_q == SRC_B) wa_ack = 1'b1;
                else                 wb_ack = 1'b1;
            end else if (wa_req) begin
                wa_ack = 1'b1;
            end else if (wb_req) begin
                wb_ack = 1'b1;
            end
        end
        if (wa_ack)      last_d = SRC_A;
        else if (wb_ack) last_d = SRC_B;

        wr_en  = wa_ack | wb_ack;
        w_addr = '0;
        w_data = '0;
        if (wa_ack) begin
            w_addr = wa_addr;
            w_data = wa_data;
        end else if (wb_ack) begin
            w_addr = wb_addr;
            w_data = wb_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) last_q <= SRC_B;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/rf_sched.sv
// Operand-fetch FSM with write forwarding, sharing the register file with a write arbiter.
module rf_sched
    import rf_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rd_req,
    input  logic [DEPTH-1:0] rd_ra,
    input  logic [DEPTH-1:0] rd_rb,
    input  logic             rd_two,
    output logic             rd_busy,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             wa_req,
    input  logic [DEPTH-1:0] wa_addr,
    input  logic [WIDTH-1:0] wa_data,
    output logic             wa_ack,
    input  logic             wb_req,
    input  logic [DEPTH-1:0] wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_ack,
    output logic [DEPTH-1:0] rf_r_addr,
    input  logic [WIDTH-1:0] rf_r_data,
    output logic             rf_wr_en,
    output logic [DEPTH-1:0] rf_w_addr,
    output logic [WIDTH-1:0] rf_w_data
);

    rd_state_e        state_q, state_d;
    logic [DEPTH-1:0] ra_q, ra_d;
    logic [DEPTH-1:0] rb_q, rb_d;
    logic             two_q, two_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;

    rf_wr_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_wr_arb (
        .clk     (clk),
        .clr     (clr),
        .wa_req  (wa_req),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .wa_ack  (wa_ack),
        .wb_req  (wb_req),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .wb_ack  (wb_ack),
        .wr_en   (rf_wr_en),
        .w_addr  (rf_w_addr),
        .w_data  (rf_w_data)
    );

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        two_d     = two_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rf_r_addr = '0;
        op_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    ra_d    = rd_ra;
                    rb_d    = rd_rb;
                    two_d   = rd_two;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                rf_r_addr = ra_q;
                // A write landing on the same register this edge wins over the stale read.
                op_a_d = (rf_wr_en && rf_w_addr == ra_q) ? rf_w_data : rf_r_data;
                if (two_q) begin
                    state_d = RD_B;
                end else begin
                    op_b_d  = '0;
                    state_d = DONE;
                end
            end
            RD_B: begin
                rf_r_addr = rb_q;
                op_b_d    = (rf_wr_en && rf_w_addr == rb_q) ? rf_w_data : rf_r_data;
                state_d   = DONE;
            end
            DONE: begin
                op_valid = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            two_q   <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            two_q   <= two_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign rd_busy = (state_q != IDLE);
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;

endmodule
